// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_TX among NUM_REQ byte sources, one byte in flight.
// Define UART_TX_ARB_TIMEOUT_EN to abandon a byte whose o_Tx_Done never arrives within TIMEOUT_CYCLES.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [8*NUM_REQ-1:0] i_req_data,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic                 o_tx_dv,
   output logic [7:0]           o_tx_byte,
   input  logic                 i_tx_active,
   input  logic                 i_tx_done,
   output logic                 o_busy,
   output logic                 o_timeout
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;
   state_t        state;
   logic [PW-1:0] ptr, win, idx;
   logic          found;
   logic [GW-1:0] gap_cnt;
   logic [NUM_REQ-1:0] sel;
   // Search starts one past the last winner and wraps, giving round-robin order.
   always_comb begin
      win = ptr;
      found = 1'b0;
      idx = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
         if (!found && i_req_valid[idx]) begin
            found = 1'b1;
            win = idx;
         end
      end
   end
   assign sel = NUM_REQ'(1) << win;
   assign o_busy = state != IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   logic          tmo_pulse;
   logic          expired;
   assign expired = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
   assign o_timeout = tmo_pulse;
`else
   // No timeout hardware in this build; the expression is constant zero.
   assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
         ptr <= PW'(NUM_REQ - 1);
         o_req_ready <= '0;
         o_grant <= '0;
         o_tx_dv <= 1'b0;
         o_tx_byte <= '0;
         gap_cnt <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         tmo_cnt <= '0;
         tmo_pulse <= 1'b0;
`endif
      end else begin
         o_tx_dv <= 1'b0;
         o_req_ready <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         tmo_pulse <= 1'b0;
`endif
         case (state)
            IDLE: if (found && !i_tx_active) begin
               o_tx_byte <= i_req_data[{win, 3'b000} +: 8];
               o_tx_dv <= 1'b1;
               o_req_ready <= sel;
               o_grant <= sel;
               ptr <= win;
               state <= WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT_DONE: if (i_tx_done) begin
               if (GAP_CYCLES == 0) begin
                  state <= IDLE;
                  o_grant <= '0;
               end else begin
                  state <= GAP;
                  gap_cnt <= GW'(GAP_CYCLES - 1);
               end
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (expired) begin
               tmo_pulse <= 1'b1;
               o_grant <= '0;
               state <= IDLE;
            end else tmo_cnt <= tmo_cnt + 1'b1;
`endif
            GAP: if (gap_cnt == '0) begin
               state <= IDLE;
               o_grant <= '0;
            end else gap_cnt <= gap_cnt - 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic checked against a cycle-level
// round-robin/timing reference model; a simple UART_TX responder drives active/done.
module tb_uart_tx_arbiter;
   localparam int N = 3, GAP = 5, TMO = 50;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0] req_ready, grant;
   logic tx_dv, busy, timeout;
   logic [7:0] tx_byte;
   logic tx_active = 1'b0, tx_done = 1'b0;
   int checks = 0, failures = 0;
   logic [7:0] src [N][256];
   int head [N] = '{default: 0};
   int tail [N] = '{default: 0};
   int rdy_cnt [N] = '{default: 0};
   logic [N-1:0] pause = '0;
   int fc = 0, frame = 4;
   bit hold_done = 0;
   int cyc = 0, owner = -1, free_e = -1, issue_e = 0, ptr = N - 1;
   logic [7:0] m_byte = '0;
   logic e_dv, e_to, e_busy;
   logic [N-1:0] e_ready, e_grant;
   int last_done_e = -100, last_dv_e = -100;
   logic s_act;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
      .o_req_ready(req_ready), .o_grant(grant), .o_tx_dv(tx_dv), .o_tx_byte(tx_byte),
      .i_tx_active(tx_active), .i_tx_done(tx_done), .o_busy(busy), .o_timeout(timeout));

   function automatic bit pending();
      for (int k = 0; k < N; k++) if (head[k] < tail[k]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         req_valid[k] = head[k] < tail[k] && !pause[k];
         req_data[8*k +: 8] = head[k] < tail[k] ? src[k][head[k]] : 8'h00;
      end
   endtask

   task automatic load(input int k, input logic [7:0] b);
      src[k][tail[k]] = b;
      tail[k]++;
      drive();
   endtask

   // One clock: advance the reference model with the inputs the edge sampled, then let the
   // requesters and the UART responder react to what the DUT produced.
   task automatic tick();
      logic [N-1:0] pv;
      logic [8*N-1:0] pdat;
      logic pa, pd, pr;
      int w;
      pv = req_valid; pdat = req_data; pa = tx_active; pd = tx_done; pr = rst_n;
      @(posedge clk);
      #1;
      cyc++;
      s_act = pa;
      if (pd) last_done_e = cyc;
      e_dv = 1'b0; e_to = 1'b0; e_ready = '0; w = -1;
      if (!pr) begin
         owner = -1; free_e = -1; ptr = N - 1; m_byte = '0;
      end else if (owner < 0) begin
         if (pv != '0 && !pa) begin
            for (int i = 1; i <= N; i++) if (w < 0 && pv[(ptr + i) % N]) w = (ptr + i) % N;
            owner = w; ptr = w; issue_e = cyc; e_dv = 1'b1;
            e_ready = N'(1) << w;
            m_byte = pdat[8*w +: 8];
         end
      end else if (free_e < 0) begin
         if (pd) free_e = cyc + GAP;
`ifdef UART_TX_ARB_TIMEOUT_EN
         else if (cyc - issue_e == TMO) begin
            e_to = 1'b1; owner = -1;
         end
`endif
      end
      if (free_e == cyc) begin
         owner = -1; free_e = -1;
      end
      e_grant = owner < 0 ? '0 : N'(1) << owner;
      e_busy = owner >= 0;
      if (tx_dv === 1'b1) last_dv_e = cyc;
      if (tx_done) tx_done = 1'b0;
      if (fc > 0) begin
         fc--;
         if (fc == 0) begin
            tx_active = 1'b0;
            tx_done = !hold_done;
         end
      end
      if (tx_dv === 1'b1) begin
         tx_active = 1'b1;
         fc = frame;
      end
      for (int k = 0; k < N; k++) if (req_ready[k] === 1'b1) begin
         head[k]++;
         rdy_cnt[k]++;
      end
      drive();
   endtask

   task automatic drain(input int budget);
      int t = 0;
      while ((busy !== 1'b0 || tx_active || tx_done || fc > 0 || pending()) && t < budget) begin
         tick();
         t++;
      end
      checks++;
      if (t >= budget) begin failures++; $display("FAIL drain_bound waited=%0d limit=%0d", t, budget); end
   endtask

   task automatic wait_dv(input int budget);
      int t = 0;
      do begin
         tick();
         t++;
      end while (tx_dv !== 1'b1 && t < budget);
      checks++;
      if (tx_dv !== 1'b1) begin failures++; $display("FAIL wait_dv got=no_issue want=issue within %0d", budget); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load(0, 8'h10); load(1, 8'h20); load(2, 8'h30);
      repeat (3) begin
         tick();
         checks++;
         if ({tx_dv, req_ready, grant, busy, timeout, tx_byte} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got dv=%b rdy=%b gnt=%b busy=%b to=%b byte=%h want all 0", tx_dv, req_ready, grant, busy, timeout, tx_byte);
         end
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (tx_dv !== 1'b1 || req_ready !== 3'b001 || grant !== 3'b001 || tx_byte !== 8'h10 || busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_grant got dv=%b rdy=%b gnt=%b byte=%h want dv=1 rdy=001 gnt=001 byte=10", tx_dv, req_ready, grant, tx_byte);
      end
      drain(200);
   endtask

   task automatic test_single();
      frame = 4;
      load(1, 8'hA5);
      tick();
      checks++;
      if (tx_dv !== 1'b1 || tx_byte !== 8'hA5 || req_ready !== 3'b010 || grant !== 3'b010) begin
         failures++;
         $display("FAIL single_issue got dv=%b byte=%h rdy=%b gnt=%b want dv=1 byte=a5 rdy=010 gnt=010", tx_dv, tx_byte, req_ready, grant);
      end
      tick();
      checks++;
      if (tx_dv !== 1'b0 || req_ready !== 3'b000 || grant !== 3'b010 || busy !== 1'b1 || tx_byte !== 8'hA5) begin
         failures++;
         $display("FAIL single_pulse got dv=%b rdy=%b gnt=%b busy=%b byte=%h want dv=0 rdy=000 gnt=010 busy=1 byte=a5", tx_dv, req_ready, grant, busy, tx_byte);
      end
      drain(100);
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_idle got gnt=%b busy=%b want gnt=000 busy=0", grant, busy);
      end
   endtask

   task automatic test_contention();
      logic [7:0] got [8] = '{default: 8'h00};
      int n = 0, t = 0, b0 = rdy_cnt[0], b1 = rdy_cnt[1];
      frame = 3;
      for (int i = 0; i < 4; i++) begin
         load(0, 8'h11); load(1, 8'h22);
      end
      while (n < 8 && t < 400) begin
         tick();
         t++;
         if (tx_dv === 1'b1) begin
            got[n] = tx_byte;
            n++;
         end
      end
      checks++;
      if (n != 8) begin failures++; $display("FAIL contention_count got=%0d want=8", n); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got[i] !== ((i % 2) ? 8'h22 : 8'h11)) begin
            failures++;
            $display("FAIL contention_order idx=%0d got=%h want=%h", i, got[i], (i % 2) ? 8'h22 : 8'h11);
         end
      end
      drain(200);
      checks++;
      if (rdy_cnt[0] - b0 != 4 || rdy_cnt[1] - b1 != 4) begin
         failures++;
         $display("FAIL contention_accepts got req0=%0d req1=%0d want 4 each", rdy_cnt[0] - b0, rdy_cnt[1] - b1);
      end
   endtask

   task automatic test_gap();
      int t = 0;
      frame = 4;
      load(0, 8'h41); load(1, 8'h42);
      wait_dv(20);
      checks++;
      if (tx_byte !== 8'h41) begin failures++; $display("FAIL gap_first_byte got=%h want=41", tx_byte); end
      do begin
         tick();
         t++;
      end while (last_done_e != cyc && t < 50);
      checks++;
      if (t >= 50) begin failures++; $display("FAIL gap_done_seen got=none want=done within 50"); end
      for (int j = 1; j <= 4; j++) begin
         tick();
         checks++;
         if (tx_dv !== 1'b0 || req_ready !== 3'b000 || busy !== 1'b1 || grant !== 3'b001) begin
            failures++;
            $display("FAIL gap_hold step=%0d got dv=%b rdy=%b busy=%b gnt=%b want dv=0 rdy=000 busy=1 gnt=001", j, tx_dv, req_ready, busy, grant);
         end
      end
      tick();
      checks++;
      if (tx_dv !== 1'b0 || busy !== 1'b0 || grant !== 3'b000) begin
         failures++;
         $display("FAIL gap_release got dv=%b busy=%b gnt=%b want dv=0 busy=0 gnt=000", tx_dv, busy, grant);
      end
      tick();
      checks++;
      if (tx_dv !== 1'b1 || tx_byte !== 8'h42 || req_ready !== 3'b010 || last_dv_e - last_done_e != GAP + 1) begin
         failures++;
         $display("FAIL gap_next_issue got dv=%b byte=%h rdy=%b spacing=%0d want dv=1 byte=42 rdy=010 spacing=%0d", tx_dv, tx_byte, req_ready, last_dv_e - last_done_e, GAP + 1);
      end
      drain(100);
   endtask

   task automatic test_busy_tx();
      frame = 8;
      load(2, 8'h77);
      wait_dv(20);
      checks++;
      if (tx_byte !== 8'h77 || req_ready !== 3'b100) begin
         failures++;
         $display("FAIL busy_issue got byte=%h rdy=%b want byte=77 rdy=100", tx_byte, req_ready);
      end
      tick();
      rst_n = 1'b0;
      load(0, 8'h5A);
      tick();
      checks++;
      if ({tx_dv, req_ready, grant, busy, tx_byte} !== '0) begin
         failures++;
         $display("FAIL busy_mid_reset got dv=%b rdy=%b gnt=%b busy=%b byte=%h want all 0", tx_dv, req_ready, grant, busy, tx_byte);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (tx_dv !== 1'b0 || s_act !== 1'b1) begin
         failures++;
         $display("FAIL busy_blocked got dv=%b active=%b want dv=0 active=1", tx_dv, s_act);
      end
      wait_dv(30);
      checks++;
      if (s_act !== 1'b0 || tx_byte !== 8'h5A || req_ready !== 3'b001) begin
         failures++;
         $display("FAIL busy_after_drop got active=%b byte=%h rdy=%b want active=0 byte=5a rdy=001", s_act, tx_byte, req_ready);
      end
      drain(100);
   endtask

   task automatic test_timeout();
      int t = 0, d;
      frame = 3;
      hold_done = 1;
      load(1, 8'h3C);
      wait_dv(20);
      d = cyc;
`ifdef UART_TX_ARB_TIMEOUT_EN
      while (timeout !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      checks++;
      if (timeout !== 1'b1 || cyc - d != TMO) begin
         failures++;
         $display("FAIL timeout_pulse got to=%b delay=%0d want to=1 delay=%0d", timeout, cyc - d, TMO);
      end
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_idle got gnt=%b busy=%b want gnt=000 busy=0", grant, busy);
      end
      tick();
      checks++;
      if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_width got=%b want=0", timeout); end
      hold_done = 0;
      load(2, 8'h4D);
      wait_dv(20);
      checks++;
      if (tx_byte !== 8'h4D || req_ready !== 3'b100) begin
         failures++;
         $display("FAIL timeout_next got byte=%h rdy=%b want byte=4d rdy=100", tx_byte, req_ready);
      end
`else
      repeat (80) begin
         tick();
         if (timeout !== 1'b0 || busy !== 1'b1) t++;
      end
      checks++;
      if (t != 0) begin failures++; $display("FAIL notimeout_wait got bad_cycles=%0d want=0 (cyc %0d)", t, cyc - d); end
      hold_done = 0;
      tx_done = 1'b1;
      tick();
`endif
      drain(100);
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_final_idle got gnt=%b busy=%b want gnt=000 busy=0", grant, busy);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         int k;
         k = $urandom_range(0, N - 1);
         if ($urandom_range(0, 2) == 0 && tail[k] - head[k] < 4) load(k, 8'($urandom));
         for (int j = 0; j < N; j++) pause[j] = ($urandom_range(0, 5) == 0);
         frame = $urandom_range(1, 6);
         drive();
         tick();
         checks++;
         if ({tx_dv, req_ready, grant, busy, timeout} !== {e_dv, e_ready, e_grant, e_busy, e_to} || tx_byte !== m_byte) begin
            failures++;
            $display("FAIL random cyc=%0d got dv=%b rdy=%b gnt=%b busy=%b to=%b byte=%h want dv=%b rdy=%b gnt=%b busy=%b to=%b byte=%h",
                     cyc, tx_dv, req_ready, grant, busy, timeout, tx_byte, e_dv, e_ready, e_grant, e_busy, e_to, m_byte);
         end
      end
      pause = '0;
      drive();
      drain(300);
      for (int j = 0; j < N; j++) begin
         checks++;
         if (head[j] != tail[j]) begin
            failures++;
            $display("FAIL random_drain req=%0d got consumed=%0d want=%0d", j, head[j], tail[j]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_gap();
      test_busy_tx();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
